// File: rtl/hangman_pkg.sv
// Shared constants, state encoding and letter-code helper for the hangman word controller.
// Latency: none (package only).
// Backpressure: none (package only).
package hangman_pkg;

  localparam logic [5:0] CODE_DASH  = 6'h00;
  localparam logic [5:0] CODE_BLANK = 6'h3F;
  localparam logic [5:0] CODE_A     = 6'h0A;
  localparam logic [5:0] CODE_Z     = 6'h23;

  localparam int DEF_WORD_LEN  = 6;
  localparam int DEF_MAX_LIVES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_CHECK,
    ST_UPDATE,
    ST_WON,
    ST_LOST
  } state_t;

  // True when the code is one of the 26 letters A..Z.
  function automatic logic is_letter(input logic [5:0] code);
    return (code >= CODE_A) && (code <= CODE_Z);
  endfunction

endpackage

// File: rtl/hangman_guess_tracker.sv
// 26-bit used-letter set: synchronous clear, combinational membership test, single-letter set.
// Latency: test is combinational; set/clear take effect on the next rising edge.
// Backpressure: none; clear has priority over set.
module hangman_guess_tracker
  import hangman_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_clear,
  input  logic       i_set,
  input  logic [5:0] i_code,
  output logic       o_used
);

  logic [25:0] r_used;
  logic [4:0]  w_idx;
  logic        w_letter;

  assign w_idx    = 5'(i_code - CODE_A);
  assign w_letter = is_letter(i_code);
  assign o_used   = w_letter && r_used[w_idx];

  // Clear on a new game, otherwise record each newly guessed letter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_used <= '0;
    end else if (i_clear) begin
      r_used <= '0;
    end else if (i_set && w_letter) begin
      r_used[w_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/hangman_word_ctrl.sv
// Hangman game controller: stores the secret word, scans each new guess one position per cycle, drives display codes.
// Latency: accepted new letter -> hit/miss pulse WORD_LEN+1 cycles; reject/repeat pulse the cycle after acceptance.
// Backpressure: guess_ready high only in READY; load_word always accepted and overrides a simultaneous guess.
module hangman_word_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int MAX_LIVES = DEF_MAX_LIVES
)
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load_word,
  input  logic [6*WORD_LEN-1:0] word_in,
  input  logic                  guess_valid,
  input  logic [5:0]            guess_code,
  output logic                  guess_ready,
  output logic [6*WORD_LEN-1:0] disp_codes,
  output logic [2:0]            lives,
  output logic                  hit,
  output logic                  miss,
  output logic                  repeat_g,
  output logic                  reject,
  output logic                  win,
  output logic                  lose
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  state_t                r_state;
  logic [6*WORD_LEN-1:0] r_word;
  logic [WORD_LEN-1:0]   r_reveal;
  logic [2:0]            r_lives;
  logic [5:0]            r_guess;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_any_hit;
  logic                  r_hit, r_miss, r_repeat, r_reject, r_win, r_lose;

  logic                  w_accept;
  logic                  w_used;
  logic                  w_is_letter;
  logic                  w_new_letter;
  logic [5:0]            w_cur_code;
  logic                  w_match;
  logic                  w_any_hit;
  logic                  w_all_revealed;
  logic                  w_load_empty;

  assign w_accept     = guess_valid && (r_state == ST_READY) && !load_word;
  assign w_is_letter  = is_letter(guess_code);
  assign w_new_letter = w_accept && w_is_letter && !w_used;
  assign w_match      = (w_cur_code == r_guess);
  assign w_any_hit    = r_any_hit || w_match;

  hangman_guess_tracker u_tracker (
    .clock   (clock),
    .resetn  (resetn),
    .i_clear (load_word),
    .i_set   (w_new_letter),
    .i_code  (guess_code),
    .o_used  (w_used)
  );

  // Select the stored code at the current scan position.
  always_comb begin
    w_cur_code = CODE_BLANK;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (r_idx == IDX_W'(i)) w_cur_code = r_word[6*i +: 6];
    end
  end

  // Win detection on the stored word and empty-word detection on the incoming word.
  always_comb begin
    w_all_revealed = 1'b1;
    w_load_empty   = 1'b1;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (is_letter(r_word[6*i +: 6]) && !r_reveal[i]) w_all_revealed = 1'b0;
      if (is_letter(word_in[6*i +: 6])) w_load_empty = 1'b0;
    end
  end

  // Per-digit display code: blank for unused, dash for hidden, letter when revealed or game lost.
  always_comb begin
    disp_codes = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (!is_letter(r_word[6*i +: 6]))
        disp_codes[6*i +: 6] = CODE_BLANK;
      else if (r_reveal[i] || (r_state == ST_LOST))
        disp_codes[6*i +: 6] = r_word[6*i +: 6];
      else
        disp_codes[6*i +: 6] = CODE_DASH;
    end
  end

  // Game FSM with registered outcome pulses, lives and game-over flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_word    <= {WORD_LEN{CODE_BLANK}};
      r_reveal  <= '0;
      r_lives   <= 3'd0;
      r_guess   <= CODE_DASH;
      r_idx     <= '0;
      r_any_hit <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_repeat  <= 1'b0;
      r_reject  <= 1'b0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_repeat <= 1'b0;
      r_reject <= 1'b0;
      if (load_word) begin
        r_word    <= word_in;
        r_reveal  <= '0;
        r_lives   <= 3'(MAX_LIVES);
        r_idx     <= '0;
        r_any_hit <= 1'b0;
        r_lose    <= 1'b0;
        r_win     <= w_load_empty;
        r_state   <= w_load_empty ? ST_WON : ST_READY;
      end else begin
        case (r_state)
          ST_READY: begin
            if (w_accept) begin
              if (!w_is_letter) begin
                r_reject <= 1'b1;
              end else if (w_used) begin
                r_repeat <= 1'b1;
              end else begin
                r_guess   <= guess_code;
                r_idx     <= '0;
                r_any_hit <= 1'b0;
                r_state   <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if ((r_idx == IDX_W'(i)) && w_match) r_reveal[i] <= 1'b1;
            end
            if (w_match) r_any_hit <= 1'b1;
            if (r_idx == LAST_IDX) begin
              // Outcome is registered here so it is visible during the single UPDATE cycle.
              r_hit  <= w_any_hit;
              r_miss <= !w_any_hit;
              if (!w_any_hit && (r_lives != 3'd0)) r_lives <= r_lives - 3'd1;
              r_state <= ST_UPDATE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          ST_UPDATE: begin
            if (w_all_revealed) begin
              r_state <= ST_WON;
              r_win   <= 1'b1;
            end else if (r_lives == 3'd0) begin
              r_state <= ST_LOST;
              r_lose  <= 1'b1;
            end else begin
              r_state <= ST_READY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign guess_ready = (r_state == ST_READY);
  assign lives       = r_lives;
  assign hit         = r_hit;
  assign miss        = r_miss;
  assign repeat_g    = r_repeat;
  assign reject      = r_reject;
  assign win         = r_win;
  assign lose        = r_lose;

endmodule
